spike_aer_encoder: RTL and testbench

- Sits directly downstream of `lif_neuron_array`.
- Converts the per-cycle parallel spike vector into a serial address-event (AER) stream of `{timestamp, neuron index}` words.
- Buffers events in a FIFO for the host/router interface.
- Accounts for events lost when spikes arrive faster than they can be serialised.

---
 rtl/spike_aer_encoder.sv | 183 ++++++++++++++++++
 tb/tb_spike_aer_encoder.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/spike_aer_encoder.sv
// Purpose: serialise parallel spike vectors into {timestamp, neuron index} AER events, buffered in a FWFT FIFO.
// Latency: vector sampled at E0, first event written at E1, ev_valid high after E1; one event per cycle.
// Backpressure: ev_ready low fills the FIFO, then the serialiser stalls; new vectors arriving while busy are dropped and counted.
//
// Ports: clk, rst (async active-high), enable (gates capture and ts counter), spikes[NUM_NEURONS],
//        ev_valid/ev_ready/ev_addr/ev_ts (event stream), fifo_level, busy, dropped_count[16].
// Optional feature macro: SPIKE_AER_DROP_CNT_EN (undefined: dropped_count tied to 0).

module spike_aer_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 32,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_vld,
    output logic             wr_rdy,
    input  logic [WIDTH-1:0] wr_dat,
    output logic             rd_vld,
    input  logic             rd_rdy,
    output logic [WIDTH-1:0] rd_dat,
    output logic [PTR_W:0]   level
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             full;
    logic             wr_fire;
    logic             rd_fire;

    assign full    = (level == (PTR_W+1)'(DEPTH));
    assign rd_vld  = (level != '0);
    assign rd_fire = rd_vld && rd_rdy;
    // A pop on the same edge frees the slot being written, so a full FIFO still accepts.
    assign wr_rdy  = !full || rd_fire;
    assign wr_fire = wr_vld && wr_rdy;
    assign rd_dat  = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            // Cleared so the head reads as zero straight out of reset.
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (wr_fire) begin
                mem[wr_ptr] <= wr_dat;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (rd_fire) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (wr_fire && !rd_fire) begin
                level <= level + (PTR_W+1)'(1);
            end else if (rd_fire && !wr_fire) begin
                level <= level - (PTR_W+1)'(1);
            end
        end
    end
endmodule

module spike_aer_encoder #(
    parameter int NUM_NEURONS = 16,
    parameter int FIFO_DEPTH  = 32,
    parameter int TS_WIDTH    = 16,
    parameter int ADDR_WIDTH  = $clog2(NUM_NEURONS)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enable,
    input  logic [NUM_NEURONS-1:0]        spikes,
    output logic                          ev_valid,
    input  logic                          ev_ready,
    output logic [ADDR_WIDTH-1:0]         ev_addr,
    output logic [TS_WIDTH-1:0]           ev_ts,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          busy,
    output logic [15:0]                   dropped_count
);
    localparam int EV_W = TS_WIDTH + ADDR_WIDTH;

    logic [TS_WIDTH-1:0]    ts_cnt;
    logic [TS_WIDTH-1:0]    pend_ts;
    logic [NUM_NEURONS-1:0] pending;
    logic [ADDR_WIDTH-1:0]  lsb_idx;
    logic                   spikes_any;
    logic                   pend_any;
    logic                   capture;
    logic                   ev_wr_rdy;
    logic                   ev_wr_fire;
    logic [EV_W-1:0]        ev_wr_dat;
    logic [EV_W-1:0]        ev_rd_dat;

    assign spikes_any = |spikes;
    assign pend_any   = |pending;
    assign capture    = enable && spikes_any && !pend_any;
    assign busy       = pend_any;

    // Priority encoder: scanning downward leaves the lowest set index.
    always_comb begin
        lsb_idx = '0;
        for (int i = NUM_NEURONS - 1; i >= 0; i--) begin
            if (pending[i]) begin
                lsb_idx = ADDR_WIDTH'(i);
            end
        end
    end

    assign ev_wr_dat  = {pend_ts, lsb_idx};
    assign ev_wr_fire = pend_any && ev_wr_rdy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ts_cnt  <= '0;
            pending <= '0;
            pend_ts <= '0;
        end else begin
            if (enable) begin
                ts_cnt <= ts_cnt + TS_WIDTH'(1);
            end
            // Capture only happens with pending empty, so it never races a push.
            if (capture) begin
                pending <= spikes;
                pend_ts <= ts_cnt;
            end else if (ev_wr_fire) begin
                pending <= pending & (pending - NUM_NEURONS'(1));
            end
        end
    end

    spike_aer_fifo #(
        .WIDTH (EV_W),
        .DEPTH (FIFO_DEPTH)
    ) u_ev_fifo (
        .clk    (clk),
        .rst    (rst),
        .wr_vld (pend_any),
        .wr_rdy (ev_wr_rdy),
        .wr_dat (ev_wr_dat),
        .rd_vld (ev_valid),
        .rd_rdy (ev_ready),
        .rd_dat (ev_rd_dat),
        .level  (fifo_level)
    );

    assign {ev_ts, ev_addr} = ev_rd_dat;

`ifdef SPIKE_AER_DROP_CNT_EN
    localparam int CNT_W = $clog2(NUM_NEURONS + 1);

    logic             drop;
    logic [CNT_W-1:0] spike_pop;
    logic [16:0]      drop_sum;
    logic [15:0]      drop_cnt;

    // A vector arriving while the serialiser is busy is discarded whole.
    assign drop = enable && spikes_any && pend_any;

    always_comb begin
        spike_pop = '0;
        for (int i = 0; i < NUM_NEURONS; i++) begin
            spike_pop = spike_pop + CNT_W'(spikes[i]);
        end
    end

    assign drop_sum = {1'b0, drop_cnt} + 17'(spike_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_cnt <= '0;
        end else if (drop) begin
            drop_cnt <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
        end
    end

    assign dropped_count = drop_cnt;
`else
    assign dropped_count = '0;
`endif
endmodule

// File: tb/tb_spike_aer_encoder.sv
// Directed bench for spike_aer_encoder: vector table plus hand-written full-FIFO, reset and wrap sequences.

module tb_spike_aer_encoder;
    logic        clk;
    logic        rst;
    logic        enable;
    logic [15:0] spikes;
    logic        ev_valid;
    logic        ev_ready;
    logic [3:0]  ev_addr;
    logic [15:0] ev_ts;
    logic [5:0]  fifo_level;
    logic        busy;
    logic [15:0] dropped_count;

    int total = 0;
    int bad   = 0;

    spike_aer_encoder dut (
        .clk           (clk),
        .rst           (rst),
        .enable        (enable),
        .spikes        (spikes),
        .ev_valid      (ev_valid),
        .ev_ready      (ev_ready),
        .ev_addr       (ev_addr),
        .ev_ts         (ev_ts),
        .fifo_level    (fifo_level),
        .busy          (busy),
        .dropped_count (dropped_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        en;
        logic [15:0] spk;
        logic        rdy;
        logic        vld;
        logic [3:0]  addr;
        logic [15:0] ts;
        logic [5:0]  lvl;
        logic        bsy;
        logic [15:0] drop;
    } vec_t;

    vec_t tbl [18];

    function automatic vec_t mk(input logic en, input logic [15:0] spk, input logic rdy,
                                input logic vld, input logic [3:0] addr, input logic [15:0] ts,
                                input logic [5:0] lvl, input logic bsy, input logic [15:0] drop);
        vec_t v;
        v.en = en; v.spk = spk; v.rdy = rdy; v.vld = vld; v.addr = addr;
        v.ts = ts; v.lvl = lvl; v.bsy = bsy; v.drop = drop;
        return v;
    endfunction

    // Expected drop count depends on whether the counter is built.
    function automatic logic [15:0] ed(input logic [15:0] v);
`ifdef SPIKE_AER_DROP_CNT_EN
        return v;
`else
        return (v == 16'd0) ? 16'd0 : 16'd0;
`endif
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step(input logic e, input logic [15:0] s, input logic r);
        enable   = e;
        spikes   = s;
        ev_ready = r;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset(input string nm);
        chk({nm, " vld"},  32'(ev_valid),      32'd0);
        chk({nm, " addr"}, 32'(ev_addr),       32'd0);
        chk({nm, " ts"},   32'(ev_ts),         32'd0);
        chk({nm, " lvl"},  32'(fifo_level),    32'd0);
        chk({nm, " busy"}, 32'(busy),          32'd0);
        chk({nm, " drop"}, 32'(dropped_count), 32'd0);
    endtask

    initial begin
        rst      = 1'b1;
        enable   = 1'b0;
        spikes   = '0;
        ev_ready = 1'b0;

        for (int i = 0; i < 5; i++) tbl[i] = mk(1, 16'h0000, 0, 0, 0, 0, 0, 0, 0);
        tbl[5]  = mk(1, 16'h0001, 0, 0, 0,  0, 0, 1, 0);  // captured at ts 5
        tbl[6]  = mk(0, 16'h0000, 0, 1, 0,  5, 1, 0, 0);
        tbl[7]  = mk(0, 16'h0000, 1, 0, 0,  0, 0, 0, 0);
        tbl[8]  = mk(1, 16'h8421, 1, 0, 0,  0, 0, 1, 0);  // captured at ts 6
        tbl[9]  = mk(0, 16'h0000, 1, 1, 0,  6, 1, 1, 0);
        tbl[10] = mk(0, 16'h0000, 1, 1, 5,  6, 1, 1, 0);
        tbl[11] = mk(0, 16'h0000, 1, 1, 10, 6, 1, 1, 0);
        tbl[12] = mk(0, 16'h0000, 1, 1, 15, 6, 1, 0, 0);
        tbl[13] = mk(0, 16'h0000, 1, 0, 0,  0, 0, 0, 0);
        tbl[14] = mk(1, 16'h0003, 1, 0, 0,  0, 0, 1, 0);  // captured at ts 7
        tbl[15] = mk(1, 16'h0100, 1, 1, 0,  7, 1, 1, 1);  // dropped, +1
        tbl[16] = mk(1, 16'h00F0, 1, 1, 1,  7, 1, 0, 5);  // same edge as last push: dropped, +4
        tbl[17] = mk(0, 16'h0000, 1, 0, 0,  0, 0, 0, 5);

        repeat (2) @(posedge clk);
        #1;
        chk_reset("reset");
        rst = 1'b0;

        for (int i = 0; i < 18; i++) begin
            step(tbl[i].en, tbl[i].spk, tbl[i].rdy);
            chk($sformatf("row%0d vld", i),  32'(ev_valid),      32'(tbl[i].vld));
            chk($sformatf("row%0d lvl", i),  32'(fifo_level),    32'(tbl[i].lvl));
            chk($sformatf("row%0d busy", i), 32'(busy),          32'(tbl[i].bsy));
            chk($sformatf("row%0d drop", i), 32'(dropped_count), 32'(ed(tbl[i].drop)));
            if (tbl[i].vld) begin
                chk($sformatf("row%0d addr", i), 32'(ev_addr), 32'(tbl[i].addr));
                chk($sformatf("row%0d ts", i),   32'(ev_ts),   32'(tbl[i].ts));
            end
        end

        // Fill with ev_ready low: 32 buffered, #32 held pending, #33..#39 dropped. ts_cnt starts at 10.
        for (int i = 0; i < 40; i++) begin
            logic [15:0] s;
            s = 16'(1) << (i % 16);
            step(1, s, 0);
            step(0, 16'h0000, 0);
        end
        chk("full lvl",  32'(fifo_level),    32'd32);
        chk("full busy", 32'(busy),          32'd1);
        chk("full drop", 32'(dropped_count), 32'(ed(16'd12)));
        step(0, 16'h0000, 0);
        step(0, 16'h0000, 0);
        chk("stall lvl",  32'(fifo_level), 32'd32);
        chk("stall busy", 32'(busy),       32'd1);
        for (int k = 0; k < 33; k++) begin
            chk($sformatf("drain%0d vld", k),  32'(ev_valid), 32'd1);
            chk($sformatf("drain%0d addr", k), 32'(ev_addr),  32'(k % 16));
            chk($sformatf("drain%0d ts", k),   32'(ev_ts),    32'(10 + k));
            step(0, 16'h0000, 1);
        end
        chk("drained vld",  32'(ev_valid),   32'd0);
        chk("drained lvl",  32'(fifo_level), 32'd0);
        chk("drained busy", 32'(busy),       32'd0);

        // Reset mid-operation with 10 buffered events and a vector pending.
        for (int i = 0; i < 10; i++) begin
            logic [15:0] s;
            s = 16'(1) << i;
            step(1, s, 0);
            step(0, 16'h0000, 0);
        end
        step(1, 16'h0006, 0);
        chk("prerst lvl",  32'(fifo_level), 32'd10);
        chk("prerst busy", 32'(busy),       32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk_reset("async rst");
        enable   = 1'b0;
        ev_ready = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step(0, 16'h0000, 1);
            chk($sformatf("postrst%0d vld", i),  32'(ev_valid), 32'd0);
            chk($sformatf("postrst%0d busy", i), 32'(busy),     32'd0);
        end

        // Timestamp wrap: 65539 enabled cycles leave ts_cnt at 3.
        repeat (65539) step(1, 16'h0000, 0);
        step(1, 16'h0040, 0);
        chk("wrap busy", 32'(busy),     32'd1);
        chk("wrap vld0", 32'(ev_valid), 32'd0);
        step(0, 16'h0000, 0);
        chk("wrap vld",  32'(ev_valid), 32'd1);
        chk("wrap addr", 32'(ev_addr),  32'd6);
        chk("wrap ts",   32'(ev_ts),    32'd3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
